// File: rtl/cram_pkg.sv
// Shared types for the CRAM write-port controller: word payload and arbiter priority encoding.
package cram_pkg;

    localparam int unsigned CRAM_AW = 8;
    localparam int unsigned CRAM_DW = 16;

    typedef struct packed {
        logic [CRAM_AW-1:0] addr;
        logic [CRAM_DW-1:0] data;
    } cram_wr_t;

    typedef enum logic {
        PRI_CPU = 1'b0,
        PRI_DMA = 1'b1
    } pri_e;

endpackage

// File: rtl/cram_wr_arb_if.sv
// Requester-side bus of the CRAM write arbiter: CPU push port, DMA req/ack port, CRAM write port.
interface cram_wr_arb_if import cram_pkg::*; ;

    logic               cpu_wr;
    logic [CRAM_AW-1:0] cpu_addr;
    logic [CRAM_DW-1:0] cpu_data;
    logic               cpu_full;
    logic               ovf;
    logic               ovf_clr;
    logic               dma_req;
    logic [CRAM_AW-1:0] dma_addr;
    logic [CRAM_DW-1:0] dma_data;
    logic               dma_ack;
    logic               cram_we;
    logic [CRAM_AW-1:0] cram_addr;
    logic [CRAM_DW-1:0] cram_data;

    modport master (
        output cpu_wr, cpu_addr, cpu_data, ovf_clr, dma_req, dma_addr, dma_data,
        input  cpu_full, ovf, dma_ack, cram_we, cram_addr, cram_data
    );

    modport slave (
        input  cpu_wr, cpu_addr, cpu_data, ovf_clr, dma_req, dma_addr, dma_data,
        output cpu_full, ovf, dma_ack, cram_we, cram_addr, cram_data
    );

endinterface

// File: rtl/cram_wfifo.sv
// Synchronous FIFO of CPU palette writes; full/empty are registered alongside the count.
module cram_wfifo import cram_pkg::*; #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  cram_wr_t               din,
    output cram_wr_t               head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    cram_wr_t          mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              pop_ok;
    logic              push_ok;
    logic [CW-1:0]     count_nxt;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    always_comb begin
        pop_ok    = pop & ~empty;
        push_ok   = push & (~full | pop_ok);
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/cram_wr_arb.sv
// CRAM write-port controller: round-robin between buffered CPU writes and DMA req/ack,
// at most one registered CRAM write per clock, optionally restricted to blanking.
module cram_wr_arb import cram_pkg::*; #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          BLANK_ONLY = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         blank,
    cram_wr_arb_if.slave bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    cram_wr_t           head;
    cram_wr_t           cpu_word;
    logic [CW-1:0]      fifo_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               slot_ok;
    logic               okc;
    logic               okd;
    logic               gnt_c;
    logic               gnt_d;
    logic               push_acc;

    pri_e               pri;
    logic               cram_we_q;
    logic               dma_ack_q;
    logic [CRAM_AW-1:0] cram_addr_q;
    logic [CRAM_DW-1:0] cram_data_q;
    logic               ovf_q;

    assign cpu_word = '{addr: bus.cpu_addr, data: bus.cpu_data};

    cram_wfifo #(.DEPTH(FIFO_DEPTH)) u_wfifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_acc),
        .pop   (gnt_c),
        .din   (cpu_word),
        .head  (head),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Eligibility and grant; the ack mask keeps a DMA that is still lowering req from a second grant.
    always_comb begin
        slot_ok  = en & (blank | ~BLANK_ONLY);
        okc      = slot_ok & ~fifo_empty;
        okd      = slot_ok & bus.dma_req & ~dma_ack_q;
        gnt_c    = okc & (~okd | (pri == PRI_CPU));
        gnt_d    = okd & (~okc | (pri == PRI_DMA));
        push_acc = bus.cpu_wr & ((fifo_cnt < CW'(FIFO_DEPTH)) | gnt_c);
    end

    // Priority FSM and registered CRAM write port; pri only moves on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri         <= PRI_CPU;
            cram_we_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cram_addr_q <= '0;
            cram_data_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            cram_we_q <= gnt_c | gnt_d;
            dma_ack_q <= gnt_d;
            if (gnt_c) begin
                cram_addr_q <= head.addr;
                cram_data_q <= head.data;
                pri         <= PRI_DMA;
            end else if (gnt_d) begin
                cram_addr_q <= bus.dma_addr;
                cram_data_q <= bus.dma_data;
                pri         <= PRI_CPU;
            end
            if (bus.cpu_wr & ~push_acc) ovf_q <= 1'b1;
            else if (bus.ovf_clr)       ovf_q <= 1'b0;
        end
    end

    assign bus.cpu_full  = fifo_full;
    assign bus.ovf       = ovf_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.cram_we   = cram_we_q;
    assign bus.cram_addr = cram_addr_q;
    assign bus.cram_data = cram_data_q;

endmodule

// File: tb/tb_cram_wr_arb.sv
// Self-checking bench for cram_wr_arb: vector table, directed corner sequences, randomized run vs. queue model.
module tb_cram_wr_arb;
    import cram_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic blank = 1'b0;
    int   checks = 0;
    int   failures = 0;

    cram_wr_arb_if if0 ();
    cram_wr_arb_if if1 ();

    cram_wr_arb #(.FIFO_DEPTH(4), .BLANK_ONLY(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .blank(blank), .bus(if0));
    cram_wr_arb #(.FIFO_DEPTH(4), .BLANK_ONLY(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .blank(blank), .bus(if1));

    always #5 clk = ~clk;

    typedef struct {
        logic        en, wr;
        logic [7:0]  a;
        logic [15:0] d;
        logic        dreq;
        logic [7:0]  da;
        logic [15:0] dd;
        logic        clr;
        logic        x_we, x_ack;
        logic [7:0]  x_a;
        logic [15:0] x_d;
        logic        x_full, x_ovf;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic addv(input logic e, input logic w, input logic [7:0] a, input logic dreq,
                        input logic [7:0] da, input logic [15:0] dd, input logic clr,
                        input logic xwe, input logic xack, input logic [7:0] xa,
                        input logic [15:0] xd, input logic xf, input logic xo);
        vec_t v;
        v.en = e; v.wr = w; v.a = a; v.d = 16'hA000 | {8'h00, a};
        v.dreq = dreq; v.da = da; v.dd = dd; v.clr = clr;
        v.x_we = xwe; v.x_ack = xack; v.x_a = xa; v.x_d = xd; v.x_full = xf; v.x_ovf = xo;
        tv.push_back(v);
    endtask

    task automatic idle();
        if0.cpu_wr = 0; if0.cpu_addr = 0; if0.cpu_data = 0; if0.ovf_clr = 0;
        if0.dma_req = 0; if0.dma_addr = 0; if0.dma_data = 0;
        if1.cpu_wr = 0; if1.cpu_addr = 0; if1.cpu_data = 0; if1.ovf_clr = 0;
        if1.dma_req = 0; if1.dma_addr = 0; if1.dma_data = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; en = 0; blank = 0; idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk_out(input string nm, input logic we, input logic ack,
                           input logic [7:0] a, input logic [15:0] d);
        chk({nm, "_we"}, 32'(if0.cram_we), 32'(we));
        chk({nm, "_ack"}, 32'(if0.dma_ack), 32'(ack));
        if (we) begin
            chk({nm, "_addr"}, 32'(if0.cram_addr), 32'(a));
            chk({nm, "_data"}, 32'(if0.cram_data), 32'(d));
        end
    endtask

    // Behavioural model state for the randomized run.
    cram_wr_t mq[$];
    int       m_pri;
    logic     m_we, m_ack, m_ovf;
    logic [7:0]  m_addr;
    logic [15:0] m_data;

    initial begin
        int stale, acked;
        idle();
        do_reset();

        // Reset state of both instances.
        chk("rst_we0", 32'(if0.cram_we), 0);     chk("rst_ack0", 32'(if0.dma_ack), 0);
        chk("rst_addr0", 32'(if0.cram_addr), 0); chk("rst_data0", 32'(if0.cram_data), 0);
        chk("rst_full0", 32'(if0.cpu_full), 0);  chk("rst_ovf0", 32'(if0.ovf), 0);
        chk("rst_we1", 32'(if1.cram_we), 0);     chk("rst_ovf1", 32'(if1.ovf), 0);

        // Vector table (dut0): single write, overflow, push+pop when full, DMA mask, ovf_clr priority.
        addv(1,1,8'h12,0,0,0,0, 0,0,8'h00,16'h0000,0,0);
        tv[0].d = 16'h7C00;
        addv(1,0,0,0,0,0,0, 1,0,8'h12,16'h7C00,0,0);
        addv(1,0,0,0,0,0,0, 0,0,8'h12,16'h7C00,0,0);
        for (int i = 1; i <= 5; i++)
            addv(0,1,8'(i),0,0,0,0, 0,0,8'h12,16'h7C00, i >= 4, i == 5);
        for (int i = 1; i <= 4; i++)
            addv(1,0,0,0,0,0,0, 1,0,8'(i),16'hA000 | 16'(i),0,1);
        addv(1,0,0,0,0,0,0, 0,0,8'h04,16'hA004,0,1);
        addv(1,0,0,0,0,0,1, 0,0,8'h04,16'hA004,0,0);
        for (int i = 0; i < 4; i++)
            addv(0,1,8'h10 + 8'(i),0,0,0,0, 0,0,8'h04,16'hA004, i == 3, 0);
        addv(1,1,8'h14,0,0,0,0, 1,0,8'h10,16'hA010,1,0);
        for (int i = 1; i <= 4; i++)
            addv(1,0,0,0,0,0,0, 1,0,8'h10 + 8'(i),16'hA010 + 16'(i),0,0);
        addv(1,0,0,0,0,0,0, 0,0,8'h14,16'hA014,0,0);
        addv(1,0,0,1,8'h55,16'h1234,0, 1,1,8'h55,16'h1234,0,0);
        addv(1,0,0,1,8'h55,16'h1234,0, 0,0,8'h55,16'h1234,0,0);
        addv(1,0,0,1,8'h56,16'h4321,0, 1,1,8'h56,16'h4321,0,0);
        addv(1,0,0,0,0,0,0, 0,0,8'h56,16'h4321,0,0);
        for (int i = 0; i < 4; i++)
            addv(0,1,8'h20 + 8'(i),0,0,0,0, 0,0,8'h56,16'h4321, i == 3, 0);
        addv(0,1,8'h24,0,0,0,1, 0,0,8'h56,16'h4321,1,1);
        addv(0,0,0,0,0,0,1, 0,0,8'h56,16'h4321,1,0);
        for (int i = 0; i < 4; i++)
            addv(1,0,0,0,0,0,0, 1,0,8'h20 + 8'(i),16'hA020 + 16'(i),0,0);
        addv(1,0,0,0,0,0,0, 0,0,8'h23,16'hA023,0,0);

        for (int i = 0; i < tv.size(); i++) begin
            en = tv[i].en;
            if0.cpu_wr = tv[i].wr; if0.cpu_addr = tv[i].a; if0.cpu_data = tv[i].d;
            if0.dma_req = tv[i].dreq; if0.dma_addr = tv[i].da; if0.dma_data = tv[i].dd;
            if0.ovf_clr = tv[i].clr;
            tick();
            chk($sformatf("vec%0d_we", i),   32'(if0.cram_we),   32'(tv[i].x_we));
            chk($sformatf("vec%0d_ack", i),  32'(if0.dma_ack),   32'(tv[i].x_ack));
            chk($sformatf("vec%0d_addr", i), 32'(if0.cram_addr), 32'(tv[i].x_a));
            chk($sformatf("vec%0d_data", i), 32'(if0.cram_data), 32'(tv[i].x_d));
            chk($sformatf("vec%0d_full", i), 32'(if0.cpu_full),  32'(tv[i].x_full));
            chk($sformatf("vec%0d_ovf", i),  32'(if0.ovf),       32'(tv[i].x_ovf));
        end

        // Contention: A0..A2 queued, DMA reissues B0..B2 after each ack; expect C,D,C,D,C,D.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if0.cpu_wr = 1; if0.cpu_addr = 8'h30 + 8'(i); if0.cpu_data = 16'h0A00 + 16'(i);
            tick();
        end
        if0.cpu_wr = 0;
        en = 1; if0.dma_req = 1; if0.dma_addr = 8'h30; if0.dma_data = 16'h0B00;
        begin
            int bi;
            bi = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (k % 2 == 0)
                    chk_out($sformatf("cont%0d", k), 1, 0, 8'h30 + 8'(k/2), 16'h0A00 + 16'(k/2));
                else
                    chk_out($sformatf("cont%0d", k), 1, 1, 8'h30 + 8'(k/2), 16'h0B00 + 16'(k/2));
                if (if0.dma_ack) begin
                    bi++;
                    if (bi < 3) begin
                        if0.dma_addr = 8'h30 + 8'(bi); if0.dma_data = 16'h0B00 + 16'(bi);
                    end else if0.dma_req = 0;
                end
            end
        end
        tick();
        chk_out("cont_end", 0, 0, 0, 0);

        // BLANK_ONLY instance: nothing commits until blank rises, then CPU then DMA.
        do_reset();
        en = 1; blank = 0;
        if1.cpu_wr = 1; if1.cpu_addr = 8'h40; if1.cpu_data = 16'h1111;
        if1.dma_req = 1; if1.dma_addr = 8'h41; if1.dma_data = 16'h2222;
        tick();
        if1.cpu_wr = 0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("blank_hold%0d", k), 32'(if1.cram_we), 0);
            tick();
        end
        chk("blank_hold3", 32'(if1.cram_we), 0);
        blank = 1;
        tick();
        chk("blank_m1_we", 32'(if1.cram_we), 1);   chk("blank_m1_ack", 32'(if1.dma_ack), 0);
        chk("blank_m1_addr", 32'(if1.cram_addr), 32'h40);
        chk("blank_m1_data", 32'(if1.cram_data), 32'h1111);
        tick();
        chk("blank_m2_we", 32'(if1.cram_we), 1);   chk("blank_m2_ack", 32'(if1.dma_ack), 1);
        chk("blank_m2_addr", 32'(if1.cram_addr), 32'h41);
        chk("blank_m2_data", 32'(if1.cram_data), 32'h2222);
        if1.dma_req = 0;
        tick();
        chk("blank_m3_we", 32'(if1.cram_we), 0);

        // Async reset mid-burst with a held DMA request.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if0.cpu_wr = 1; if0.cpu_addr = 8'h60 + 8'(i); if0.cpu_data = 16'h6000 + 16'(i);
            tick();
        end
        en = 1; if0.cpu_addr = 8'h64; if0.cpu_data = 16'h6004;
        if0.dma_req = 1; if0.dma_addr = 8'h77; if0.dma_data = 16'h5A5A;
        tick();
        if0.cpu_wr = 0;
        chk_out("rst_mid_pre", 1, 0, 8'h60, 16'h6000);
        chk("rst_mid_pre_full", 32'(if0.cpu_full), 1);
        #1 rst_n = 0;
        #1;
        chk("rst_mid_we", 32'(if0.cram_we), 0);
        chk("rst_mid_full", 32'(if0.cpu_full), 0);
        chk("rst_mid_ack", 32'(if0.dma_ack), 0);
        @(posedge clk); #1 rst_n = 1;
        stale = 0; acked = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (if0.cram_we && !if0.dma_ack) stale++;
            if (if0.dma_ack) begin
                if (k < 2) acked = 1;
                chk("rst_dma_addr", 32'(if0.cram_addr), 32'h77);
                chk("rst_dma_data", 32'(if0.cram_data), 32'h5A5A);
                if0.dma_req = 0;
            end
        end
        chk("rst_dma_acked", 32'(acked), 1);
        chk("rst_stale_cpu", 32'(stale), 0);

        // Randomized run against a queue-based model of the sharing rules.
        do_reset();
        mq.delete(); m_pri = 0; m_we = 0; m_ack = 0; m_ovf = 0; m_addr = 0; m_data = 0;
        for (int n = 0; n < 1500; n++) begin
            bit cok, dok, dropped;
            cram_wr_t w;
            en = ($urandom_range(0, 9) != 0);
            blank = 1'($urandom);
            if0.cpu_wr = ($urandom_range(0, 2) != 0);
            if0.cpu_addr = 8'($urandom); if0.cpu_data = 16'($urandom);
            if0.ovf_clr = ($urandom_range(0, 15) == 0);
            if (!if0.dma_req || m_ack) begin
                if (m_ack && $urandom_range(0, 1) == 0) if0.dma_req = 0;
                else begin
                    if0.dma_req = (m_ack || $urandom_range(0, 3) == 0);
                    if0.dma_addr = 8'($urandom); if0.dma_data = 16'($urandom);
                end
            end
            cok = en && mq.size() > 0;
            dok = en && if0.dma_req && !m_ack;
            m_we = 0; m_ack = 0;
            if (cok && (!dok || m_pri == 0)) begin
                w = mq.pop_front();
                m_we = 1; m_addr = w.addr; m_data = w.data; m_pri = 1;
            end else if (dok) begin
                m_we = 1; m_ack = 1; m_addr = if0.dma_addr; m_data = if0.dma_data; m_pri = 0;
            end
            dropped = 0;
            if (if0.cpu_wr) begin
                if (mq.size() < 4) mq.push_back('{addr: if0.cpu_addr, data: if0.cpu_data});
                else dropped = 1;
            end
            if (dropped) m_ovf = 1;
            else if (if0.ovf_clr) m_ovf = 0;
            tick();
            chk("rnd_we", 32'(if0.cram_we), 32'(m_we));
            chk("rnd_ack", 32'(if0.dma_ack), 32'(m_ack));
            chk("rnd_addr", 32'(if0.cram_addr), 32'(m_addr));
            chk("rnd_data", 32'(if0.cram_data), 32'(m_data));
            chk("rnd_full", 32'(if0.cpu_full), 32'(mq.size() == 4));
            chk("rnd_ovf", 32'(if0.ovf), 32'(m_ovf));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
